// File: rtl/cva6_pma_unit.sv
// Runtime-programmable physical-memory-attribute checker: NrRules lockable address
// windows resolved by lowest-index priority through a two-stage valid/ready pipeline.
module cva6_pma_unit #(
  parameter int unsigned   NrRules   = 4,
  parameter int unsigned   AddrWidth = 64,
  parameter logic [1023:0] RstBase   = '0,
  parameter logic [1023:0] RstLength = '0,
  parameter logic [47:0]   RstAttr   = '0,
  localparam int unsigned  IdxW      = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [2:0]           cfg_attr_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IdxW-1:0]      rsp_rule_o,
  output logic                 rsp_exec_o,
  output logic                 rsp_cached_o,
  output logic                 rsp_nonidem_o,
  output logic [15:0]          miss_cnt_o
);

  localparam int unsigned AW1 = AddrWidth + 1;

  typedef enum logic {EMPTY, FULL} stage_e;

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [2:0]           attr_q [NrRules];
  logic [NrRules-1:0]   lock_q;

  logic            idx_ok, lock_sel, cfg_apply, cfg_err_q;
  logic            m_hit;
  logic [IdxW-1:0] m_idx;
  logic [2:0]      m_attr;

  stage_e s1_q, s1_d, s2_q, s2_d;
  logic   s1_adv, accept;

  logic            s1_hit_q, s2_hit_q;
  logic [IdxW-1:0] s1_idx_q, s2_idx_q;
  logic [2:0]      s1_attr_q, s2_attr_q;
  logic [15:0]     miss_q;

  // Config write qualification: index in range and target rule unlocked
  always_comb begin
    lock_sel = 1'b0;
    for (int i = 0; i < int'(NrRules); i++) begin
      if (cfg_idx_i == IdxW'(i)) lock_sel = lock_q[i];
    end
    idx_ok    = ({1'b0, cfg_idx_i} < (IdxW + 1)'(NrRules));
    cfg_apply = cfg_we_i && idx_ok && !lock_sel;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrRules); i++) begin
        base_q[i] <= RstBase[64*i +: AddrWidth];
        len_q[i]  <= RstLength[64*i +: AddrWidth];
        attr_q[i] <= RstAttr[3*i +: 3];
      end
      lock_q <= '0;
    end else if (cfg_apply) begin
      for (int i = 0; i < int'(NrRules); i++) begin
        if (cfg_idx_i == IdxW'(i)) begin
          base_q[i] <= cfg_base_i;
          len_q[i]  <= cfg_len_i;
          attr_q[i] <= cfg_attr_i;
          if (cfg_lock_i) lock_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cfg_err_q <= 1'b0;
    else         cfg_err_q <= cfg_we_i && !cfg_apply;
  end

  // Window match; descending scan so the lowest matching index is assigned last
  always_comb begin
    m_hit  = 1'b0;
    m_idx  = '0;
    m_attr = 3'b100;
    for (int i = int'(NrRules) - 1; i >= 0; i--) begin
      if ((len_q[i] != '0) && (req_addr_i >= base_q[i]) &&
          ({1'b0, req_addr_i} < AW1'({1'b0, base_q[i]} + {1'b0, len_q[i]}))) begin
        m_hit  = 1'b1;
        m_idx  = IdxW'(i);
        m_attr = attr_q[i];
      end
    end
  end

  // Stage occupancy next-state and request handshake
  always_comb begin
    s1_d        = s1_q;
    s2_d        = s2_q;
    s1_adv      = (s1_q == FULL) && ((s2_q == EMPTY) || rsp_ready_i);
    req_ready_o = (s1_q == EMPTY) || s1_adv;
    accept      = req_valid_i && req_ready_o && !flush_i;
    if (flush_i) begin
      s1_d = EMPTY;
      s2_d = EMPTY;
    end else begin
      if ((s2_q == EMPTY) || rsp_ready_i) s2_d = s1_q;
      if (accept)      s1_d = FULL;
      else if (s1_adv) s1_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= EMPTY;
      s2_q <= EMPTY;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // Stage payloads; S2 only reloads when it is free to change
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_hit_q  <= 1'b0;
      s1_idx_q  <= '0;
      s1_attr_q <= 3'b100;
      s2_hit_q  <= 1'b0;
      s2_idx_q  <= '0;
      s2_attr_q <= 3'b100;
    end else begin
      if (accept) begin
        s1_hit_q  <= m_hit;
        s1_idx_q  <= m_idx;
        s1_attr_q <= m_attr;
      end
      if (s1_adv && !flush_i) begin
        s2_hit_q  <= s1_hit_q;
        s2_idx_q  <= s1_idx_q;
        s2_attr_q <= s1_attr_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_q <= '0;
    end else if ((s2_q == FULL) && rsp_ready_i && !flush_i && !s2_hit_q &&
                 (miss_q != 16'hFFFF)) begin
      miss_q <= miss_q + 16'd1;
    end
  end

  assign cfg_err_o     = cfg_err_q;
  assign rsp_valid_o   = (s2_q == FULL);
  assign rsp_hit_o     = s2_hit_q;
  assign rsp_rule_o    = s2_idx_q;
  assign rsp_exec_o    = s2_attr_q[0];
  assign rsp_cached_o  = s2_attr_q[1];
  assign rsp_nonidem_o = s2_attr_q[2];
  assign miss_cnt_o    = miss_q;

endmodule

// File: tb/tb_cva6_pma_unit.sv
// Scoreboard bench for cva6_pma_unit: a predictor queues expected responses from a
// window-list reference model; a monitor pops and compares on each delivered response.
module tb_cva6_pma_unit;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 2;
  localparam logic [1023:0] RST_BASE =
    1024'({64'h0000_0000_8000_0000, 64'h0000_0000_0001_0000, 64'h0});
  localparam logic [1023:0] RST_LEN =
    1024'({64'h0000_0000_4000_0000, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_1000});
  localparam logic [47:0] RST_ATTR = 48'({3'b011, 3'b001, 3'b001});

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_len = '0;
  logic [2:0]    cfg_attr = '0;
  logic          cfg_lock = 1'b0;
  logic          cfg_err;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_hit;
  logic [IW-1:0] rsp_rule;
  logic          rsp_exec, rsp_cached, rsp_nonidem;
  logic [15:0]   miss_cnt;

  cva6_pma_unit #(
    .NrRules(NR), .AddrWidth(AW), .RstBase(RST_BASE), .RstLength(RST_LEN), .RstAttr(RST_ATTR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_base_i(cfg_base), .cfg_len_i(cfg_len),
    .cfg_attr_i(cfg_attr), .cfg_lock_i(cfg_lock), .cfg_err_o(cfg_err),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit),
    .rsp_rule_o(rsp_rule), .rsp_exec_o(rsp_exec), .rsp_cached_o(rsp_cached),
    .rsp_nonidem_o(rsp_nonidem), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit run = 1'b0;

  // Expected response: {hit, rule, exec, cached, nonidem} plus the sample cycle of acceptance
  typedef struct {
    logic [5:0] v;
    int         acc;
  } exp_t;
  exp_t sb[$];

  logic [AW-1:0] mbase [NR];
  logic [AW-1:0] mlen  [NR];
  logic [2:0]    mattr [NR];
  bit            mlock [NR];
  bit            err_pend = 1'b0;
  logic [15:0]   exp_miss = '0;
  bit            prev_stall = 1'b0;
  logic [5:0]    prev_rsp, cur_rsp;
  bit            exp_ready, exp_valid;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] ref_lookup(input logic [AW-1:0] a);
    for (int i = 0; i < int'(NR); i++) begin
      logic [AW:0] lo, hi;
      lo = {1'b0, mbase[i]};
      hi = lo + {1'b0, mlen[i]};
      if (mlen[i] != 0 && {1'b0, a} >= lo && {1'b0, a} < hi)
        return {1'b1, IW'(i), mattr[i][0], mattr[i][1], mattr[i][2]};
    end
    return 6'b000001;
  endfunction

  // Predictor: handshake expectations, then lookups against the old rules, then the write
  always @(negedge clk) begin
    if (rst_n && run) begin
      exp_ready = (sb.size() < 2) || rsp_ready;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("cfg_err", 64'(cfg_err), 64'(err_pend));
      if (flush) sb.delete();
      else if (req_valid && exp_ready) sb.push_back('{ref_lookup(req_addr), cyc});
      err_pend = 1'b0;
      if (cfg_we) begin
        if (int'(cfg_idx) < int'(NR) && !mlock[cfg_idx]) begin
          mbase[cfg_idx] = cfg_base;
          mlen[cfg_idx]  = cfg_len;
          mattr[cfg_idx] = cfg_attr;
          if (cfg_lock) mlock[cfg_idx] = 1'b1;
        end else begin
          err_pend = 1'b1;
        end
      end
    end
  end

  // Monitor: latency, ordering, stall stability and miss accounting
  always @(negedge clk) begin
    #1;
    if (rst_n && run) begin
      cur_rsp = {rsp_hit, rsp_rule, rsp_exec, rsp_cached, rsp_nonidem};
      chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
      if (!flush) begin
        exp_valid = 1'b0;
        if (sb.size() > 0) exp_valid = (cyc >= sb[0].acc + 2);
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
        if (prev_stall) chk("stall_hold", 64'(cur_rsp), 64'(prev_rsp));
        if (exp_valid) begin
          chk("rsp_data", 64'(cur_rsp), 64'(sb[0].v));
          if (rsp_ready) begin
            if (!sb[0].v[5] && exp_miss != 16'hFFFF) exp_miss++;
            void'(sb.pop_front());
          end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_rsp   = cur_rsp;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    cfg_lock = 1'b0;
    flush = 1'b0;
  endtask

  task automatic cfg_write(input logic [IW-1:0] idx, input logic [AW-1:0] b,
                           input logic [AW-1:0] l, input logic [2:0] at, input logic lk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_base = b; cfg_len = l; cfg_attr = at; cfg_lock = lk;
    tick();
  endtask

  task automatic lookup(input logic [AW-1:0] a);
    bit acc;
    bit done = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int n = 0; n < 50 && !done; n++) begin
      acc = req_ready && !flush;
      tick();
      done = acc;
    end
    req_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL lookup_timeout actual=not_accepted expected=accepted addr=%h", a);
    end
  endtask

  task automatic drain(input int n);
    rsp_ready = 1'b1;
    repeat (n) tick();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int k = $urandom_range(0, int'(NR) - 1);
    case ($urandom_range(0, 4))
      0: return mbase[k];
      1: return mbase[k] + mlen[k] - 64'd1;
      2: return mbase[k] + mlen[k];
      3: return mbase[k] - 64'd1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  function automatic logic [AW-1:0] pick_len();
    case ($urandom_range(0, 4))
      0: return 64'h0;
      1: return 64'h100;
      2: return 64'h1000;
      3: return 64'h1_0000;
      default: return 64'($urandom());
    endcase
  endfunction

  function automatic logic [AW-1:0] pick_base();
    case ($urandom_range(0, 3))
      0: return 64'h8000_0000;
      1: return 64'hFFFF_FFFF_FFFF_F000;
      2: return 64'h0;
      default: return {32'h0, $urandom()} & ~64'hFF;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < int'(NR); i++) begin
      mbase[i] = RST_BASE[64*i +: 64];
      mlen[i]  = RST_LEN[64*i +: 64];
      mattr[i] = RST_ATTR[3*i +: 3];
      mlock[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_hit", 64'(rsp_hit), 64'd0);
    chk("rst_rule", 64'(rsp_rule), 64'd0);
    chk("rst_exec", 64'(rsp_exec), 64'd0);
    chk("rst_cached", 64'(rsp_cached), 64'd0);
    chk("rst_nonidem", 64'(rsp_nonidem), 64'd1);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    rst_n = 1'b1;
    run = 1'b1;
    tick();

    // Reset-rule lookups and boundaries
    rsp_ready = 1'b1;
    lookup(64'h8000_0040);
    lookup(64'h1_FFFF);
    lookup(64'h2_0000);
    drain(4);
    chk("miss_after_boundary", 64'(miss_cnt), 64'd1);

    // Overlap: rule 0 reprogrammed inside rule 2's window
    cfg_write(2'd0, 64'h8000_0000, 64'h100, 3'b100, 1'b0);
    lookup(64'h8000_0010);
    lookup(64'h8000_0100);
    drain(4);

    // Top of address space
    cfg_write(2'd2, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b001, 1'b0);
    lookup(64'hFFFF_FFFF_FFFF_FFFF);
    lookup(64'h0);
    drain(4);

    // Lock, rejected rewrite, out-of-range index
    cfg_write(2'd1, 64'h1_0000, 64'h1_0000, 3'b001, 1'b1);
    cfg_write(2'd1, 64'h0, 64'h0, 3'b110, 1'b0);
    tick();
    lookup(64'h1_0004);
    cfg_write(2'd3, 64'h0, 64'h10, 3'b111, 1'b0);
    drain(4);

    // Backpressure: two acceptances then stall for the rest of five cycles
    rsp_ready = 1'b0;
    lookup(64'h1_0008);
    lookup(64'h2_0000);
    req_valid = 1'b1;
    req_addr  = 64'hFFFF_FFFF_FFFF_F800;
    repeat (3) tick();
    rsp_ready = 1'b1;
    lookup(64'hFFFF_FFFF_FFFF_F800);
    drain(4);

    // Flush with both stages holding misses
    rsp_ready = 1'b0;
    lookup(64'h3000_0000);
    lookup(64'h3000_0004);
    flush = 1'b1;
    tick();
    tick();
    chk("flush_valid", 64'(rsp_valid), 64'd0);
    drain(3);

    // Config write on the same edge as a lookup acceptance
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_base = 64'hFFFF_FFFF_FFFF_F000;
    cfg_len = 64'h1000; cfg_attr = 3'b110;
    lookup(64'hFFFF_FFFF_FFFF_F010);
    lookup(64'hFFFF_FFFF_FFFF_F010);
    drain(4);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = pick_addr();
      rsp_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 24) == 0) begin
        flush = 1'b1;
        rsp_ready = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        cfg_we   = 1'b1;
        cfg_idx  = IW'($urandom_range(0, 3));
        cfg_base = pick_base();
        cfg_len  = pick_len();
        cfg_attr = 3'($urandom());
        cfg_lock = ($urandom_range(0, 60) == 0);
      end
      tick();
    end
    req_valid = 1'b0;
    drain(8);
    chk("queue_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cva6_pma_unit.md
# cva6_pma_unit

Runtime-programmable physical-memory-attribute checker: the parametrised successor to the static execute/cached/non-idempotent region rules of the core configuration. It holds `NrRules` address windows, each carrying exec/cached/non-idempotent attributes and a sticky lock, and answers address lookups through a two-stage valid/ready pipeline. It sits beside the fetch and load/store units.

## Interface
- `NrRules`, 4: number of region rules (1..16).
- `AddrWidth`, 64: address width in bits.
- `RstBase`, 1024'h0: packed reset bases; rule i at bits [64*i +: AddrWidth].
- `RstLength`, 1024'h0: packed reset lengths, same packing; length 0 disables the rule.
- `RstAttr`, 48'h0: packed reset attributes, 3 bits per rule, {nonidem, cached, exec}.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. Asynchronous, active-low.
- `flush_i`  in  1  kill all in-flight lookups.
- `cfg_we_i`  in  1  rule write strobe.
- `cfg_idx_i`  in  $clog2(NrRules) (min 1)  rule index.
- `cfg_base_i`  in  AddrWidth  new base.
- `cfg_len_i`  in  AddrWidth  new length.
- `cfg_attr_i`  in  3  new {nonidem, cached, exec}.
- `cfg_lock_i`  in  1  set the rule's lock with this write.
- `cfg_err_o`  out  1  one-cycle pulse: write rejected.
- `req_valid_i`  in  1  lookup valid.
- `req_ready_o`  out  1  lookup accepted.
- `req_addr_i`  in  AddrWidth  lookup address.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_hit_o`  out  1  some rule matched.
- `rsp_rule_o`  out  $clog2(NrRules) (min 1)  index of the winning rule.
- `rsp_exec_o`, `rsp_cached_o`, `rsp_nonidem_o`  out  1 each  resolved attributes.
- `miss_cnt_o`  out  16  saturating count of delivered miss responses.

## Operation
- **Rule state.** Per rule: base, length, attr, lock. Reset loads base/length/attr from the `Rst*` parameters and clears lock.
- **Config write.** When `cfg_we_i` is high and rule `cfg_idx_i` is unlocked, update base/length/attr. If `cfg_lock_i` is also high, set lock; lock stays set until reset.
- **Rejected writes.** A write to a locked rule, or with `cfg_idx_i` >= `NrRules`, changes nothing and sets `cfg_err_o` high on the next cycle for one cycle.
- **Match rule.** Rule i matches when length != 0 and base <= addr < base + length. The sum is computed in AddrWidth+1 bits, so windows that reach the top of the address space do not wrap.
- **Priority.** The lowest matching index wins. On a hit, attributes come from the winning rule.
- **Miss response.** `rsp_hit_o`=0, exec=0, cached=0, nonidem=1, `rsp_rule_o`=0.
- **Stage 1 (S1).** On acceptance, register the winning index, the hit flag and the attributes.
- **Stage 2 (S2).** The output register; drives all `rsp_*` outputs.
- **Stage states.** Each stage is EMPTY or FULL.
  - S2 loads from S1 when S2 is EMPTY or `rsp_ready_i` is high.
  - `req_ready_o` = S1 EMPTY, or S1 advancing this cycle. It depends combinationally on `rsp_ready_i`.
- **Stalls.** While `rsp_valid_o` is high and `rsp_ready_i` is low, every `rsp_*` output holds stable.
- **Miss counter.** `miss_cnt_o` increments on each handshake with `rsp_hit_o`=0, and saturates at 16'hFFFF.
- **Flush.** `flush_i` empties S1 and S2 on the next edge. `req_ready_o` stays unaffected and may be high, but a request presented in the flush cycle is not accepted and is dropped. A flushed response is not counted.

## Timing
- **Reset values.** `req_ready_o`=1. `rsp_valid_o`, `rsp_hit_o`, `rsp_rule_o`, `rsp_exec_o`, `rsp_cached_o`, `cfg_err_o` all 0. `rsp_nonidem_o`=1. `miss_cnt_o`=0.
- **Latency and throughput.** A request accepted at edge N gives `rsp_valid_o`=1 after edge N+1, i.e. visible in cycle N+2. Throughput is one lookup per cycle when `rsp_ready_i` is held high.
- **Config visibility.** A config write at edge N affects lookups accepted at edge N+1 or later.
- **Write and lookup at the same edge.** The lookup uses the old rule values.
- **In-flight lookups.** Results already held in S1 or S2 are not re-evaluated by later writes.
- **Backpressure.** With S1 and S2 both FULL and `rsp_ready_i`=0, `req_ready_o`=0.
- **Reset mid-operation.** Reset asserted mid-operation asynchronously returns all state to reset values; in-flight lookups are lost.

## Test plan
- **Reset defaults.** NrRules=3, bases {0x0, 0x1_0000, 0x8000_0000}, lengths {0x1000, 0x10000, 0x4000_0000}, attrs {exec}, {exec}, {exec, cached}. Lookup 0x8000_0040 → hit, rule 2, exec=1, cached=1, nonidem=0, two cycles after acceptance.
- **Boundaries and overlap.**
  - 0x1_FFFF → hit, rule 1.
  - 0x2_0000 → miss, nonidem=1, `miss_cnt_o`=1.
  - Program rule 0 as base 0x8000_0000, len 0x100, nonidem; lookup 0x8000_0010 → rule 0 wins, nonidem=1.
- **Top of address space.** Rule with base 0xFFFF_FFFF_FFFF_F000, len 0x1000: 0xFFFF_FFFF_FFFF_FFFF → hit; 0x0 → not matched by that rule.
- **Lock.**
  - Write rule 1 with `cfg_lock_i`=1, then write rule 1 again → `cfg_err_o` pulses one cycle later; contents unchanged.
  - Write to index 3 with NrRules=3 → error pulse.
- **Backpressure.** Back-to-back lookups with `rsp_ready_i`=0 for 5 cycles → `req_ready_o` drops after two acceptances; outputs stay stable; both responses then drain in order with nothing lost.
- **Flush and write timing.**
  - Flush with both stages FULL → `rsp_valid_o`=0 next cycle; miss count unchanged.
  - Config write at the same edge as a lookup acceptance → the response reflects the old rule.
